smg_scan_ctrl: RTL and testbench

//  Scan controller directly upstream of the 4-digit seven-segment decoder. It owns the

---
 rtl/smg_scan_ctrl.sv | 64 ++++++
 tb/tb_smg_scan_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/smg_scan_ctrl.sv
// rtl/smg_scan_ctrl.sv - digit-scan prescaler, bitsel rotation and frame-aligned display register
// Accepts new display values through a one-entry buffer and commits them only at frame ends.
module smg_scan_ctrl #(
   parameter int          DIV_WIDTH = 16,
   parameter int unsigned DIV_MAX   = 49999
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scan_en,
   input  logic [15:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic [15:0] data_out,
   output logic [1:0]  bitsel,
   output logic        frame_done
);

   localparam logic [DIV_WIDTH-1:0] CNT_MAX = DIV_WIDTH'(DIV_MAX);

   logic [DIV_WIDTH-1:0] cnt;
   logic [15:0]          pend_data;
   logic                 pend_valid;
   logic                 tick;
   logic                 frame_end;
   logic                 accept;

   assign tick      = scan_en && (cnt == CNT_MAX);
   assign frame_end = tick && (bitsel == 2'b11);
   assign din_ready = ~pend_valid;
   assign accept    = din_valid && din_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         bitsel     <= 2'b00;
         frame_done <= 1'b0;
      end else begin
         if (tick)
            cnt <= '0;
         else if (scan_en)
            cnt <= cnt + DIV_WIDTH'(1);
         if (tick)
            bitsel <= bitsel + 2'd1;
         frame_done <= frame_end;
      end
   end

   // Commit needs pend_valid=1 and accept needs pend_valid=0, so they never collide;
   // a value accepted on a frame_end cycle waits for the following frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= 16'h0000;
         pend_data  <= 16'h0000;
         pend_valid <= 1'b0;
      end else if (frame_end && pend_valid) begin
         data_out   <= pend_data;
         pend_valid <= 1'b0;
      end else if (accept) begin
         pend_data  <= din;
         pend_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// tb/tb_smg_scan_ctrl.sv - directed vector bench for smg_scan_ctrl with a 4-cycle digit slot
// Vectors hold inputs for a number of cycles, then compare outputs 1 time unit after the edge.
module tb_smg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        scan_en;
   logic [15:0] din;
   logic        din_valid;
   logic        din_ready;
   logic [15:0] data_out;
   logic [1:0]  bitsel;
   logic        frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          adv;
      logic        vld;
      logic [15:0] d;
      logic [1:0]  bs;
      logic [15:0] dat;
      logic        fd;
      logic        rdy;
   } vec_t;

   vec_t tbl[$];

   smg_scan_ctrl #(.DIV_WIDTH(16), .DIV_MAX(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_en    (scan_en),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .data_out   (data_out),
      .bitsel     (bitsel),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [1:0] bs, input logic [15:0] dat,
                            input logic fd, input logic rdy);
      check({tag, " bitsel"}, {14'd0, bitsel}, {14'd0, bs});
      check({tag, " data_out"}, data_out, dat);
      check({tag, " frame_done"}, {15'd0, frame_done}, {15'd0, fd});
      check({tag, " din_ready"}, {15'd0, din_ready}, {15'd0, rdy});
   endtask

   initial begin
      // adv, din_valid, din, exp bitsel, exp data_out, exp frame_done, exp din_ready
      tbl.push_back('{1,  1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0, 1'b1});
      tbl.push_back('{3,  1'b0, 16'h0000, 2'd1, 16'h0000, 1'b0, 1'b1});
      tbl.push_back('{4,  1'b0, 16'h0000, 2'd2, 16'h0000, 1'b0, 1'b1});
      tbl.push_back('{4,  1'b0, 16'h0000, 2'd3, 16'h0000, 1'b0, 1'b1});
      tbl.push_back('{3,  1'b0, 16'h0000, 2'd3, 16'h0000, 1'b0, 1'b1});
      tbl.push_back('{1,  1'b0, 16'h0000, 2'd0, 16'h0000, 1'b1, 1'b1});
      tbl.push_back('{1,  1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0, 1'b1});
      tbl.push_back('{1,  1'b1, 16'h1234, 2'd0, 16'h0000, 1'b0, 1'b0});
      tbl.push_back('{13, 1'b0, 16'h0000, 2'd3, 16'h0000, 1'b0, 1'b0});
      tbl.push_back('{1,  1'b0, 16'h0000, 2'd0, 16'h1234, 1'b1, 1'b1});
      tbl.push_back('{1,  1'b1, 16'hABCD, 2'd0, 16'h1234, 1'b0, 1'b0});
      tbl.push_back('{1,  1'b1, 16'hEF01, 2'd0, 16'h1234, 1'b0, 1'b0});
      tbl.push_back('{13, 1'b1, 16'hEF01, 2'd3, 16'h1234, 1'b0, 1'b0});
      tbl.push_back('{1,  1'b1, 16'hEF01, 2'd0, 16'hABCD, 1'b1, 1'b1});
      tbl.push_back('{1,  1'b1, 16'hEF01, 2'd0, 16'hABCD, 1'b0, 1'b0});
      tbl.push_back('{14, 1'b0, 16'h0000, 2'd3, 16'hABCD, 1'b0, 1'b0});
      tbl.push_back('{1,  1'b0, 16'h0000, 2'd0, 16'hEF01, 1'b1, 1'b1});
      tbl.push_back('{15, 1'b0, 16'h0000, 2'd3, 16'hEF01, 1'b0, 1'b1});
      tbl.push_back('{1,  1'b1, 16'h5555, 2'd0, 16'hEF01, 1'b1, 1'b0});
      tbl.push_back('{15, 1'b0, 16'h0000, 2'd3, 16'hEF01, 1'b0, 1'b0});
      tbl.push_back('{1,  1'b0, 16'h0000, 2'd0, 16'h5555, 1'b1, 1'b1});

      rst_n     = 1'b0;
      scan_en   = 1'b0;
      din       = 16'h0000;
      din_valid = 1'b0;
      step();
      step();
      rst_n   = 1'b1;
      scan_en = 1'b1;
      check_all("reset", 2'd0, 16'h0000, 1'b0, 1'b1);

      foreach (tbl[i]) begin
         din_valid = tbl[i].vld;
         din       = tbl[i].d;
         repeat (tbl[i].adv) step();
         check_all($sformatf("vec%0d", i), tbl[i].bs, tbl[i].dat, tbl[i].fd, tbl[i].rdy);
      end
      din_valid = 1'b0;

      // Freeze scanning mid-slot at bitsel=10, load one value, stall a second
      repeat (9) step();
      check("pre_stall bitsel", {14'd0, bitsel}, 16'd2);
      scan_en   = 1'b0;
      din_valid = 1'b1;
      din       = 16'h0F0F;
      step();
      check("stall accept ready", {15'd0, din_ready}, 16'd0);
      din = 16'h1111;
      for (int k = 1; k < 20; k++) begin
         step();
         check_all($sformatf("stall%0d", k), 2'd2, 16'h5555, 1'b0, 1'b0);
      end
      din_valid = 1'b0;
      scan_en   = 1'b1;
      repeat (6) step();
      check_all("resume pre", 2'd3, 16'h5555, 1'b0, 1'b0);
      step();
      check_all("resume commit", 2'd0, 16'h0F0F, 1'b1, 1'b1);

      // Reset while a value is pending at bitsel=11
      din_valid = 1'b1;
      din       = 16'h7777;
      step();
      din_valid = 1'b0;
      repeat (12) step();
      check_all("pre_reset", 2'd3, 16'h0F0F, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_reset", 2'd0, 16'h0000, 1'b0, 1'b1);
      step();
      rst_n = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         step();
         check($sformatf("post_reset%0d data_out", k), data_out, 16'h0000);
         if (k == 4)
            check("post_reset bitsel", {14'd0, bitsel}, 16'd1);
         if (k == 16)
            check_all("post_reset frame", 2'd0, 16'h0000, 1'b1, 1'b1);
         if (k == 17)
            check("post_reset fd low", {15'd0, frame_done}, 16'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
